// File: rtl/usb4_ll_pkg.sv
// Shared types and constants for the USB4 logical layer: FSM states, config
// register map, generation encodings and default ordered-set symbols.
package usb4_ll_pkg;

    typedef enum logic [2:0] {
        ST_CLD     = 3'd0,
        ST_SB_WAIT = 3'd1,
        ST_TS1     = 3'd2,
        ST_TS2     = 3'd3,
        ST_CL0     = 3'd4
    } ll_state_e;

    localparam logic [7:0] ADDR_CTRL       = 8'h00;
    localparam logic [7:0] ADDR_STATUS     = 8'h01;
    localparam logic [7:0] ADDR_GEN_ACTIVE = 8'h02;

    localparam logic [1:0] GEN2 = 2'd0;
    localparam logic [1:0] GEN3 = 2'd1;
    localparam logic [1:0] GEN4 = 2'd2;

    localparam logic [7:0]  TS1_SYM_DEF = 8'h4B;
    localparam logic [7:0]  TS2_SYM_DEF = 8'h45;
    localparam logic [31:0] CTRL_RST    = 32'h0000_0006;

    // The reserved encoding 3 is stored as gen4.
    function automatic logic [1:0] gen_clamp(input logic [1:0] g);
        return (g == 2'd3) ? GEN4 : g;
    endfunction

endpackage

// File: rtl/usb4_logical_layer_core_if.sv
// Config-space bus between the config master and the logical layer core.
interface usb4_logical_layer_core_if;
    logic        c_read;
    logic        c_write;
    logic [7:0]  c_address;
    logic [31:0] c_data_in;
    logic [31:0] c_data_out;

    modport master (output c_read, c_write, c_address, c_data_in, input c_data_out);
    modport slave  (input c_read, c_write, c_address, c_data_in, output c_data_out);
endinterface

// File: rtl/usb4_ll_cfg_regs.sv
// Config register file: CTRL (RW), STATUS (RO) and GEN_ACTIVE (RO) with a
// registered read port that holds its value between reads.
module usb4_ll_cfg_regs
    import usb4_ll_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    usb4_logical_layer_core_if.slave cfg,
    input  logic [2:0]               state,
    input  logic                     cl0,
    input  logic [7:0]               fail_cnt,
    input  logic                     ts1_entry,
    output logic                     link_en,
    output logic                     lane1_en
);
    logic [1:0]  gen_q;
    logic [1:0]  gen_active_q;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign unused_wdata = ^cfg.c_data_in[31:4];

    always_comb begin
        rd_mux = '0;
        case (cfg.c_address)
            ADDR_CTRL:       rd_mux = {28'd0, link_en, lane1_en, gen_q};
            ADDR_STATUS:     rd_mux = {16'd0, fail_cnt, 4'd0, cl0, state};
            ADDR_GEN_ACTIVE: rd_mux = {30'd0, gen_active_q};
            default:         rd_mux = '0;
        endcase
    end

    // A write in the same cycle as a read suppresses the read update.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_q          <= CTRL_RST[1:0];
            lane1_en       <= CTRL_RST[2];
            link_en        <= CTRL_RST[3];
            gen_active_q   <= '0;
            cfg.c_data_out <= '0;
        end else begin
            if (cfg.c_write) begin
                if (cfg.c_address == ADDR_CTRL) begin
                    gen_q    <= gen_clamp(cfg.c_data_in[1:0]);
                    lane1_en <= cfg.c_data_in[2];
                    link_en  <= cfg.c_data_in[3];
                end
            end else if (cfg.c_read) begin
                cfg.c_data_out <= rd_mux;
            end
            if (ts1_entry) begin
                gen_active_q <= gen_q;
            end
        end
    end

endmodule

// File: rtl/usb4_logical_layer_core.sv
// USB4 logical layer for one router port: sideband bring-up, two-lane TS1/TS2
// training and CL0 byte transfer, plus the config-space register file.
module usb4_logical_layer_core
    import usb4_ll_pkg::*;
#(
    parameter int unsigned SB_DEBOUNCE   = 8,
    parameter int unsigned TS_COUNT      = 16,
    parameter int unsigned TRAIN_TIMEOUT = 4096,
    parameter logic [7:0]  TS1_SYM       = TS1_SYM_DEF,
    parameter logic [7:0]  TS2_SYM       = TS2_SYM_DEF
) (
    input  logic                     local_clk,
    input  logic                     rst,
    input  logic                     lane_disable,
    usb4_logical_layer_core_if.slave cfg,
    input  logic [7:0]               transport_layer_data_in,
    output logic [7:0]               transport_layer_data_out,
    output logic                     transport_data_flag,
    input  logic [7:0]               lane_0_rx_i,
    input  logic [7:0]               lane_1_rx_i,
    input  logic                     enable_deser,
    output logic [7:0]               lane_0_tx_o,
    output logic [7:0]               lane_1_tx_o,
    output logic                     enable_scr,
    input  logic                     sbrx,
    output logic                     sbtx,
    output logic                     cl0_s
);
    localparam int SB_W = $clog2(SB_DEBOUNCE + 1);
    localparam int TS_W = $clog2(TS_COUNT + 1);
    localparam int TO_W = $clog2(TRAIN_TIMEOUT + 1);
    localparam logic [SB_W-1:0] SB_MAX = SB_W'(SB_DEBOUNCE);
    localparam logic [TS_W-1:0] TS_MAX = TS_W'(TS_COUNT);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TRAIN_TIMEOUT);

    ll_state_e       state_q, state_d;
    logic [SB_W-1:0] sb_hi_q, sb_hi_d, sb_lo_q, sb_lo_d;
    logic [TS_W-1:0] ts0_q, ts0_d, ts1_q, ts1_d;
    logic [TO_W-1:0] tmr_q, tmr_d;
    logic            lane1_act_q, lane1_act_d;
    logic [7:0]      fail_cnt_q;
    logic            ctrl_link_en, ctrl_lane1_en;
    logic [7:0]      rx_sym, tx_sym;
    logic            in_training, sb_monitored, lane1_done, ts1_entry;

    function automatic logic [TS_W-1:0] ts_sat_inc(input logic [TS_W-1:0] c);
        return (c == TS_MAX) ? c : c + TS_W'(1);
    endfunction

    function automatic logic [7:0] fail_sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    always_comb begin
        in_training  = (state_q == ST_SB_WAIT) || (state_q == ST_TS1) || (state_q == ST_TS2);
        sb_monitored = (state_q == ST_TS1) || (state_q == ST_TS2) || (state_q == ST_CL0);
        rx_sym       = (state_q == ST_TS2) ? TS2_SYM : TS1_SYM;
        state_d      = state_q;
        ts0_d        = ts0_q;
        ts1_d        = ts1_q;
        sb_hi_d      = '0;
        sb_lo_d      = '0;
        tmr_d        = in_training ? tmr_q + TO_W'(1) : '0;

        if ((state_q == ST_SB_WAIT) && sbrx) sb_hi_d = sb_hi_q + SB_W'(1);
        // Low-level run spans TS1, TS2 and CL0 without restarting.
        if (sb_monitored && !sbrx) sb_lo_d = sb_lo_q + SB_W'(1);
        if (((state_q == ST_TS1) || (state_q == ST_TS2)) && enable_deser) begin
            ts0_d = (lane_0_rx_i == rx_sym) ? ts_sat_inc(ts0_q) : '0;
            ts1_d = (lane_1_rx_i == rx_sym) ? ts_sat_inc(ts1_q) : '0;
        end
        lane1_done = !lane1_act_q || (ts1_d == TS_MAX);

        unique case (state_q)
            ST_CLD:     if (!lane_disable && ctrl_link_en) state_d = ST_SB_WAIT;
            ST_SB_WAIT: if (sb_hi_d == SB_MAX) state_d = ST_TS1;
            ST_TS1:     if ((ts0_d == TS_MAX) && lane1_done) state_d = ST_TS2;
            ST_TS2:     if ((ts0_d == TS_MAX) && lane1_done) state_d = ST_CL0;
            ST_CL0:     state_d = ST_CL0;
            default:    state_d = ST_CLD;
        endcase

        if (state_q != ST_CLD) begin
            if (lane_disable || !ctrl_link_en || (sb_lo_d == SB_MAX) ||
                (in_training && (tmr_d == TO_MAX)))
                state_d = ST_CLD;
        end

        if (state_d != state_q) begin
            ts0_d   = '0;
            ts1_d   = '0;
            tmr_d   = '0;
            sb_hi_d = '0;
        end

        // Lane 1 enable is sampled once per training attempt.
        ts1_entry   = (state_q != ST_TS1) && (state_d == ST_TS1);
        lane1_act_d = ts1_entry ? ctrl_lane1_en : lane1_act_q;
        tx_sym      = (state_d == ST_TS2) ? TS2_SYM : TS1_SYM;
    end

    always_ff @(posedge local_clk) begin
        if (rst) begin
            state_q     <= ST_CLD;
            sb_hi_q     <= '0;
            sb_lo_q     <= '0;
            ts0_q       <= '0;
            ts1_q       <= '0;
            tmr_q       <= '0;
            lane1_act_q <= 1'b0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sb_hi_q     <= sb_hi_d;
            sb_lo_q     <= sb_lo_d;
            ts0_q       <= ts0_d;
            ts1_q       <= ts1_d;
            tmr_q       <= tmr_d;
            lane1_act_q <= lane1_act_d;
            if ((state_q != ST_CLD) && (state_d == ST_CLD))
                fail_cnt_q <= fail_sat_inc(fail_cnt_q);
        end
    end

    // Outputs follow the next state so they change on the same edge as the FSM.
    always_ff @(posedge local_clk) begin
        if (rst) begin
            sbtx                     <= 1'b0;
            cl0_s                    <= 1'b0;
            enable_scr               <= 1'b0;
            lane_0_tx_o              <= '0;
            lane_1_tx_o              <= '0;
            transport_layer_data_out <= '0;
            transport_data_flag      <= 1'b0;
        end else begin
            sbtx                <= (state_d != ST_CLD);
            cl0_s               <= (state_d == ST_CL0);
            enable_scr          <= (state_d == ST_CL0);
            transport_data_flag <= 1'b0;
            unique case (state_d)
                ST_TS1, ST_TS2: begin
                    lane_0_tx_o <= tx_sym;
                    lane_1_tx_o <= lane1_act_d ? tx_sym : 8'h00;
                end
                ST_CL0: begin
                    lane_0_tx_o <= transport_layer_data_in;
                    lane_1_tx_o <= lane1_act_d ? transport_layer_data_in : 8'h00;
                    if (enable_deser) begin
                        transport_layer_data_out <= lane_0_rx_i;
                        transport_data_flag      <= 1'b1;
                    end
                end
                default: begin
                    lane_0_tx_o <= '0;
                    lane_1_tx_o <= '0;
                end
            endcase
        end
    end

    usb4_ll_cfg_regs u_cfg_regs (
        .clk       (local_clk),
        .rst       (rst),
        .cfg       (cfg),
        .state     (state_q),
        .cl0       (cl0_s),
        .fail_cnt  (fail_cnt_q),
        .ts1_entry (ts1_entry),
        .link_en   (ctrl_link_en),
        .lane1_en  (ctrl_lane1_en)
    );

endmodule

// File: tb/tb_usb4_logical_layer_core.sv
// Self-checking bench for usb4_logical_layer_core: config vector table,
// randomized config/CL0 traffic against a simple model, and training sequences.
module tb_usb4_logical_layer_core;
    localparam logic [7:0] TS1 = 8'h4B;
    localparam logic [7:0] TS2 = 8'h45;

    logic       local_clk = 1'b0;
    logic       rst = 1'b1;
    logic       lane_disable = 1'b1;
    logic       enable_deser = 1'b0;
    logic       sbrx = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] rx0 = 8'h00;
    logic [7:0] rx1 = 8'h00;
    logic [7:0] data_out, lane0, lane1;
    logic       flag, enable_scr, sbtx, cl0_s;

    int checks = 0;
    int errors = 0;

    usb4_logical_layer_core_if cfg();

    always #5 local_clk = ~local_clk;

    usb4_logical_layer_core dut (
        .local_clk                (local_clk),
        .rst                      (rst),
        .lane_disable             (lane_disable),
        .cfg                      (cfg),
        .transport_layer_data_in  (data_in),
        .transport_layer_data_out (data_out),
        .transport_data_flag      (flag),
        .lane_0_rx_i              (rx0),
        .lane_1_rx_i              (rx1),
        .enable_deser             (enable_deser),
        .lane_0_tx_o              (lane0),
        .lane_1_tx_o              (lane1),
        .enable_scr               (enable_scr),
        .sbrx                     (sbrx),
        .sbtx                     (sbtx),
        .cl0_s                    (cl0_s)
    );

    typedef struct {
        logic        do_wr;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [7:0]  ra;
        logic [31:0] exp;
    } cfg_vec_t;

    cfg_vec_t vecs[10];

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cfg_op(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d);
        cfg.c_read    = rd;
        cfg.c_write   = wr;
        cfg.c_address = a;
        cfg.c_data_in = d;
        tick();
        cfg.c_read  = 1'b0;
        cfg.c_write = 1'b0;
    endtask

    task automatic feed(input int n, input logic [7:0] s0, input logic [7:0] s1);
        for (int i = 0; i < n; i++) begin
            rx0 = s0;
            rx1 = s1;
            enable_deser = 1'b1;
            tick();
        end
        enable_deser = 1'b0;
    endtask

    task automatic wait_sym(input logic [7:0] sym, input int bound, input string name);
        int n = 0;
        while (lane0 !== sym && n < bound) begin
            tick();
            n++;
        end
        check(name, lane0, sym);
    endtask

    // Reference model of the register file while the link is held in CLD.
    function automatic logic [31:0] model_read(input logic [7:0] a, input logic [31:0] ctrl);
        if (a == 8'h00) return ctrl;
        return 32'h0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] mctrl, exp_rd, d;
        logic [7:0]  a, exp_tx, exp_out;
        logic        rd, wr, exp_flag;
        int          n;

        cfg.c_read = 1'b0;
        cfg.c_write = 1'b0;
        cfg.c_address = 8'h00;
        cfg.c_data_in = 32'h0;

        vecs[0] = '{1'b0, 8'h00, 32'h0,        8'h00, 32'h6};
        vecs[1] = '{1'b0, 8'h00, 32'h0,        8'h01, 32'h0};
        vecs[2] = '{1'b0, 8'h00, 32'h0,        8'h02, 32'h0};
        vecs[3] = '{1'b1, 8'h40, 32'hFFFFFFFF, 8'h40, 32'h0};
        vecs[4] = '{1'b1, 8'h01, 32'hFFFFFFFF, 8'h01, 32'h0};
        vecs[5] = '{1'b1, 8'h00, 32'h1,        8'h00, 32'h1};
        vecs[6] = '{1'b1, 8'h00, 32'h3,        8'h00, 32'h2};
        vecs[7] = '{1'b1, 8'h00, 32'hFFFFFFF8, 8'h00, 32'h8};
        vecs[8] = '{1'b1, 8'h00, 32'h7,        8'h00, 32'h6};
        vecs[9] = '{1'b1, 8'h02, 32'h3,        8'h02, 32'h0};

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", {sbtx, cl0_s, enable_scr, flag, lane0, lane1, data_out}, 32'h0);
        check("reset_rdata", cfg.c_data_out, 32'h0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) cfg_op(1'b0, 1'b1, vecs[i].wa, vecs[i].wd);
            cfg_op(1'b1, 1'b0, vecs[i].ra, 32'h0);
            check($sformatf("cfg_vec%0d", i), cfg.c_data_out, vecs[i].exp);
        end

        cfg_op(1'b1, 1'b0, 8'h00, 32'h0);
        check("ctrl_read", cfg.c_data_out, 32'h6);
        cfg_op(1'b1, 1'b1, 8'h00, 32'h5);
        check("rw_collision_hold", cfg.c_data_out, 32'h6);
        cfg_op(1'b0, 1'b0, 8'h01, 32'h0);
        check("idle_hold", cfg.c_data_out, 32'h6);
        cfg_op(1'b1, 1'b0, 8'h00, 32'h0);
        check("rw_collision_write", cfg.c_data_out, 32'h5);

        mctrl  = 32'h5;
        exp_rd = 32'h5;
        for (int i = 0; i < 150; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: a = 8'h00;
                1: a = 8'h01;
                2: a = 8'h02;
                default: a = 8'($urandom);
            endcase
            d = $urandom;
            if (rd && !wr) exp_rd = model_read(a, mctrl);
            if (wr && a == 8'h00) mctrl = {28'd0, d[3], d[2], (d[1:0] == 2'd3) ? 2'd2 : d[1:0]};
            cfg_op(rd, wr, a, d);
            check("rand_cfg", cfg.c_data_out, exp_rd);
        end

        // Normal bring-up with both lanes.
        cfg_op(1'b0, 1'b1, 8'h00, 32'hE);
        sbrx = 1'b1;
        lane_disable = 1'b0;
        wait_sym(TS1, 40, "enter_ts1");
        check("ts1_lanes_sbtx", {sbtx, lane1}, {1'b1, TS1});
        cfg_op(1'b1, 1'b0, 8'h01, 32'h0);
        check("status_ts1", cfg.c_data_out, 32'h2);
        data_in = 8'h77;
        feed(1, 8'h11, 8'h11);
        check("early_cmd_dropped", {lane0, lane1, flag}, {TS1, TS1, 1'b0});
        data_in = 8'h00;
        feed(15, TS1, TS1);
        check("ts1_15_stay", lane0, TS1);
        feed(1, TS1, TS1);
        check("ts2_enter", {lane0, lane1}, {TS2, TS2});
        cfg_op(1'b1, 1'b0, 8'h01, 32'h0);
        check("status_ts2", cfg.c_data_out, 32'h3);
        feed(16, TS2, TS2);
        check("cl0_flags", {cl0_s, enable_scr, sbtx}, 3'b111);
        cfg_op(1'b1, 1'b0, 8'h01, 32'h0);
        check("status_cl0", cfg.c_data_out, 32'hC);
        cfg_op(1'b1, 1'b0, 8'h02, 32'h0);
        check("gen_active_gen4", cfg.c_data_out, 32'h2);

        data_in = 8'hA5;
        tick();
        check("cl0_tx", {lane0, lane1}, {8'hA5, 8'hA5});
        rx0 = 8'h3C;
        enable_deser = 1'b1;
        tick();
        enable_deser = 1'b0;
        check("cl0_rx", {flag, data_out}, {1'b1, 8'h3C});
        tick();
        check("cl0_rx_hold", {flag, data_out}, {1'b0, 8'h3C});

        exp_out = 8'h3C;
        for (int i = 0; i < 200; i++) begin
            data_in = 8'($urandom);
            rx0 = 8'($urandom);
            rx1 = 8'($urandom);
            enable_deser = 1'($urandom_range(0, 1));
            exp_tx = data_in;
            exp_flag = enable_deser;
            if (enable_deser) exp_out = rx0;
            tick();
            check("rand_cl0", {lane0, lane1, flag, data_out}, {exp_tx, exp_tx, exp_flag, exp_out});
        end
        enable_deser = 1'b0;

        // Sideband loss: 7 low cycles are tolerated, 8 drop the link.
        sbrx = 1'b0;
        repeat (7) tick();
        sbrx = 1'b1;
        tick();
        check("sbrx_low7_keeps_cl0", cl0_s, 1'b1);
        sbrx = 1'b0;
        repeat (7) tick();
        check("sbrx_low_7_of_8", cl0_s, 1'b1);
        tick();
        check("sbrx_low8_cld", {cl0_s, sbtx, lane0}, {1'b0, 1'b0, 8'h00});
        cfg_op(1'b1, 1'b0, 8'h01, 32'h0);
        check("status_fail1", cfg.c_data_out, 32'h100);
        check("reenter_sbwait", sbtx, 1'b1);

        // Training timeout in TS1.
        sbrx = 1'b1;
        wait_sym(TS1, 40, "reenter_ts1");
        n = 0;
        while (lane0 === TS1 && n < 5000) begin
            tick();
            n++;
        end
        check("ts1_timeout_cycles", n, 4096);
        check("timeout_cld", sbtx, 1'b0);
        cfg_op(1'b1, 1'b0, 8'h01, 32'h0);
        check("status_fail2", cfg.c_data_out, 32'h200);
        check("timeout_reenter_sbwait", sbtx, 1'b1);

        lane_disable = 1'b1;
        tick();
        check("lane_disable_cld", sbtx, 1'b0);
        cfg_op(1'b1, 1'b0, 8'h01, 32'h0);
        check("status_fail3", cfg.c_data_out, 32'h300);

        // Single-lane training: lane 1 ignored and driven 0.
        cfg_op(1'b0, 1'b1, 8'h00, 32'h8);
        lane_disable = 1'b0;
        wait_sym(TS1, 40, "lane1_off_enter_ts1");
        check("lane1_off_ts1", lane1, 8'h00);
        feed(16, TS1, 8'h00);
        check("lane1_off_ts2", {lane0, lane1}, {TS2, 8'h00});
        feed(16, TS2, 8'h00);
        check("lane1_off_cl0", cl0_s, 1'b1);
        cfg_op(1'b1, 1'b0, 8'h02, 32'h0);
        check("gen_active_gen2", cfg.c_data_out, 32'h0);
        data_in = 8'h5A;
        tick();
        check("lane1_off_tx", {lane0, lane1}, {8'h5A, 8'h00});

        cfg_op(1'b0, 1'b1, 8'h00, 32'h0);
        tick();
        check("link_en_off_cld", {cl0_s, sbtx}, 2'b00);
        cfg_op(1'b1, 1'b0, 8'h01, 32'h0);
        check("status_fail4", cfg.c_data_out, 32'h400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb4_logical_layer_core.md
Name: usb4_logical_layer_core

Overview:
- Simplified USB4 logical layer for one router port.
- Runs sideband bring-up, two-lane ordered-set link training, and CL0 data transfer between the transport layer and two 8-bit parallel electrical-layer lanes.
- Exposes a small configuration-space register file.
- Sits between the transport layer (upper), the electrical/PHY layer (lower) and the config-space master.

Parameters:
- SB_DEBOUNCE, 8: consecutive cycles sbrx must hold a level before it is accepted.
- TS_COUNT, 16: consecutive matching ordered sets required on both lanes per training phase.
- TRAIN_TIMEOUT, 4096: maximum cycles in any single training state before falling back to CLD.
- TS1_SYM, 8'h4B: TS1 ordered-set symbol.
- TS2_SYM, 8'h45: TS2 ordered-set symbol.

Ports:
- local_clk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- lane_disable  in  1  forces CLD while high.
- c_read  in  1  config read strobe.
- c_write  in  1  config write strobe.
- c_address  in  8  config register address.
- c_data_in  in  32  config write data.
- c_data_out  out  32  config read data.
- transport_layer_data_in  in  8  byte to transmit in CL0.
- transport_layer_data_out  out  8  received byte.
- transport_data_flag  out  1  transport_layer_data_out is valid this cycle.
- lane_0_rx_i  in  8  lane 0 received symbol.
- lane_1_rx_i  in  8  lane 1 received symbol.
- enable_deser  in  1  rx symbols are valid this cycle.
- lane_0_tx_o  out  8  lane 0 transmit symbol.
- lane_1_tx_o  out  8  lane 1 transmit symbol.
- enable_scr  out  1  tells the PHY to scramble; high only in CL0.
- sbrx  in  1  sideband receive level.
- sbtx  out  1  sideband transmit level.
- cl0_s  out  1  link is in CL0.

Behaviour:
- Reset values: all outputs 0; FSM in CLD; CTRL register = 32'h0000_0006 (gen4, lane 1 enabled).
- All outputs are registered, giving 1-cycle latency from inputs.
- FSM states and transitions:
  - CLD: sbtx=0, lanes output 0. Exits to SB_WAIT when lane_disable=0 and CTRL.link_en=1.
  - SB_WAIT: sbtx=1. Exits to TS1 after sbrx=1 for SB_DEBOUNCE consecutive cycles.
  - TS1: both tx lanes output TS1_SYM. A per-lane counter increments on each enable_deser cycle whose rx symbol equals TS1_SYM and clears on any valid mismatch. Exits to TS2 when both counters reach TS_COUNT.
  - TS2: same rule with TS2_SYM. Exits to CL0.
  - CL0: cl0_s=1, enable_scr=1.
- Lane 1 is ignored (treated as always matched and driven 0) when CTRL.lane1_en=0.
- Fallback to CLD, one cycle after the triggering condition:
  - lane_disable=1 in any state;
  - sbrx=0 for SB_DEBOUNCE consecutive cycles in TS1, TS2 or CL0;
  - the timeout counter reaching TRAIN_TIMEOUT in SB_WAIT, TS1 or TS2. The counter resets on every state entry.
- Each fallback to CLD increments STATUS.fail_cnt, saturating at 255.
- CL0 transmit: lane_0_tx_o = transport_layer_data_in. lane_1_tx_o = the same byte if lane 1 is enabled, else 0.
- CL0 receive: on enable_deser=1, transport_layer_data_out = lane_0_rx_i and transport_data_flag=1 for one cycle. Otherwise the flag is 0 and the data is held.
- Outside CL0: transport_layer_data_in is ignored and transport_data_flag stays 0, so early commands are dropped.
- Config registers; unmapped addresses read 0 and ignore writes:
  - 0x00 CTRL, RW: bits[1:0] gen (0=gen2, 1=gen3, 2=gen4; 3 is written as 2); bit2 lane1_en; bit3 link_en.
  - 0x01 STATUS, RO: bits[2:0] state (CLD=0, SB_WAIT=1, TS1=2, TS2=3, CL0=4); bit3 cl0_s; bits[15:8] fail_cnt.
  - 0x02 GEN_ACTIVE, RO: the gen value latched on entry to TS1.
- Reads have 1-cycle latency. c_data_out holds its value when c_read=0.
- Simultaneous c_read and c_write: the write wins and c_data_out is not updated.
- A CTRL write while in TS1, TS2 or CL0 takes effect on the next training attempt, except link_en=0, which forces CLD immediately.

Decomposition:
- Package usb4_ll_pkg holds:
  - the state enum;
  - register addresses;
  - gen encodings;
  - the TS1_SYM and TS2_SYM defaults.
- One sub-module, usb4_ll_cfg_regs: the register file plus read mux, taking state, cl0 and fail_cnt as inputs.
- The FSM, counters and datapath stay in the top.

Test Plan:
- Reset, then check registers: hold rst 3 cycles, then read 0x00 and 0x01 -> 32'h6 and 32'h0; all outputs 0.
- Normal bring-up: write 0x00=32'hE; drive sbrx=1; feed TS1_SYM on both lanes for 16 valid cycles, then TS2_SYM for 16 -> sbtx=1, state 2 then 3, cl0_s=1, enable_scr=1, STATUS reads 32'h0000_000C.
- CL0 data: drive in=8'hA5 -> both tx lanes=8'hA5 next cycle. Drive rx0=8'h3C with enable_deser -> out=8'h3C and flag=1 for one cycle.
- Early command: send transport_layer_data_in during TS1 -> tx lanes stay TS1_SYM and flag stays 0.
- Training failure: in TS1, send no matching symbols for 4096 cycles -> CLD, fail_cnt=1; the FSM then re-enters SB_WAIT.
- SBRX low: in CL0, drop sbrx for 8 cycles -> cl0_s=0, state CLD, sbtx=0. Also check that 7 low cycles keep CL0.
